// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
//   Two-line buffer feeding a 3x3 Sobel window stage. For every accepted
//   raster pixel it presents the vertical 3-pixel column at that position:
//   two rows above, one row above and the current pixel.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   pixel_i      : raster-order grey pixel (row-major, left to right)
//   valid_i      : pixel_i accepted on a rising edge where valid_i = 1
//   d0_o         : same column, two rows above (top window row)
//   d1_o         : same column, one row above (middle window row)
//   d2_o         : current pixel (bottom window row)
//   done_o       : d0_o..d2_o hold a complete 3-row column
//   frame_done_o : one-cycle pulse after the last pixel of a frame
module sobel_line_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] d0_o,
  output logic [DATA_W-1:0] d1_o,
  output logic [DATA_W-1:0] d2_o,
  output logic              done_o,
  output logic              frame_done_o
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] FIRST_FULL_ROW = RW'(2);

  // L1 holds the previous row, L2 the row before that.
  logic [DATA_W-1:0] l1_q [IMG_WIDTH];
  logic [DATA_W-1:0] l2_q [IMG_WIDTH];

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic              done_q, done_d;
  logic              frame_done_q, frame_done_d;

  logic accept;
  logic last_col;
  logic last_pix;

  // A pixel offered during reset is dropped, so reset gates acceptance.
  assign accept   = valid_i && !rst;
  assign last_col = (col_q == LAST_COL);
  assign last_pix = last_col && (row_q == LAST_ROW);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    d0_d         = d0_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    done_d       = 1'b0;
    frame_done_d = 1'b0;
    if (valid_i) begin
      d0_d         = l2_q[col_q];
      d1_d         = l1_q[col_q];
      d2_d         = pixel_i;
      // Row gating keeps stale rows from a previous frame (or from before a
      // reset) from ever being reported as a valid column.
      done_d       = (row_q >= FIRST_FULL_ROW);
      frame_done_d = last_pix;
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line memories are not reset; both reads above see the pre-edge contents,
  // so the shift L1 -> L2 and the new write land on the same edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      l2_q[col_q] <= l1_q[col_q];
      l1_q[col_q] <= pixel_i;
    end
  end

  assign d0_o         = d0_q;
  assign d1_o         = d1_q;
  assign d2_o         = d2_q;
  assign done_o       = done_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb_sobel_line_buffer
//   Directed bench for sobel_line_buffer with a 4x4 image, pixel = row*16+col
//   (plus a per-frame base offset). Expected windows are derived from the
//   pixel formula, not from the DUT.
module tb_sobel_line_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [DW-1:0] pixel;
  logic [DW-1:0] d0_o, d1_o, d2_o;
  logic          done_o, frame_done_o;

  int checks = 0;
  int passes = 0;

  sobel_line_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_i     (pixel),
    .valid_i     (valid),
    .d0_o        (d0_o),
    .d1_o        (d1_o),
    .d2_o        (d2_o),
    .done_o      (done_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive inputs away from the rising edge, then sample just after it.
  task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] p);
    @(negedge clk);
    rst   = r;
    valid = v;
    pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_d0"}, 32'(d0_o), 32'h0);
    checkOutput({tag, "_d1"}, 32'(d1_o), 32'h0);
    checkOutput({tag, "_d2"}, 32'(d2_o), 32'h0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'h0);
    checkOutput({tag, "_fdone"}, 32'(frame_done_o), 32'h0);
  endtask

  // Streams one frame starting at row 0 col 0. gapAt inserts three idle
  // cycles after that pixel index; stopAt truncates the frame.
  task automatic sendFrame(input logic [DW-1:0] base, input int gapAt,
                           input int stopAt, input bit countDone);
    int pulses;
    pulses = 0;
    for (int i = 0; i < W*H; i++) begin
      int r;
      int c;
      logic [DW-1:0] p;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
      if (i > stopAt) break;
      r  = i / W;
      c  = i % W;
      p  = base + DW'(r*16 + c);
      e0 = p - 8'h20;
      e1 = p - 8'h10;
      applyStimulus(1'b0, 1'b1, p);
      checkOutput($sformatf("done_r%0dc%0d", r, c), 32'(done_o), 32'(r >= 2));
      checkOutput($sformatf("fdone_r%0dc%0d", r, c), 32'(frame_done_o), 32'(i == W*H-1));
      if (done_o) pulses++;
      if (r >= 2) begin
        checkOutput($sformatf("d0_r%0dc%0d", r, c), 32'(d0_o), 32'(e0));
        checkOutput($sformatf("d1_r%0dc%0d", r, c), 32'(d1_o), 32'(e1));
        checkOutput($sformatf("d2_r%0dc%0d", r, c), 32'(d2_o), 32'(p));
      end
      if (i == gapAt) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(1'b0, 1'b0, 8'hEE);
          checkOutput($sformatf("gap%0d_done", g), 32'(done_o), 32'h0);
          checkOutput($sformatf("gap%0d_d0", g), 32'(d0_o), 32'(e0));
          checkOutput($sformatf("gap%0d_d1", g), 32'(d1_o), 32'(e1));
          checkOutput($sformatf("gap%0d_d2", g), 32'(d2_o), 32'(p));
        end
      end
    end
    if (countDone) checkOutput("done_count", 32'(pulses), 32'(W*(H-2)));
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    pixel = '0;

    // Reset together with a valid 0xFF pixel: the pixel must be dropped.
    applyStimulus(1'b1, 1'b1, 8'hFF);
    checkReset("reset");

    // Frame 1 contiguous, frame 2 (+0x80) back-to-back with no idle cycle.
    sendFrame(8'h00, -1, W*H-1, 1'b1);
    sendFrame(8'h80, -1, W*H-1, 1'b1);

    // Frame 3 with a 3-cycle gap after pixel 0x21 (index 9).
    sendFrame(8'h00, 9, W*H-1, 1'b1);

    // Partial frame up to 0x21, then reset mid-frame and a fresh frame.
    sendFrame(8'h00, -1, 9, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkReset("midreset");
    sendFrame(8'h00, -1, W*H-1, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
